// File: rtl/dz_countdown_ctrl_if.sv
// Control/status bundle between the button front end, the countdown sequencer and the
// dot-matrix renderer.
//   start, pause, clear : 1-cycle command pulses into the sequencer
//   num                 : digit to display
//   row_idx, row_sel    : current scan row (binary and one-hot)
//   busy, done          : phase flags
interface dz_countdown_ctrl_if;
    logic       start;
    logic       pause;
    logic       clear;
    logic [2:0] num;
    logic [2:0] row_idx;
    logic [7:0] row_sel;
    logic       busy;
    logic       done;

    // Command source / display consumer side.
    modport master (
        output start, pause, clear,
        input  num, row_idx, row_sel, busy, done
    );

    // Sequencer side.
    modport slave (
        input  start, pause, clear,
        output num, row_idx, row_sel, busy, done
    );
endinterface

// File: rtl/dz_countdown_ctrl.sv
// Countdown sequencer for the 8x8 dual-colour dot-matrix display.
// Counts START_NUM down to 0 at one digit per tick, holds a DONE phase for DONE_HOLD
// ticks, then returns to idle. Independently generates a free-running row-scan index.
// Ports:
//   clk  : system clock, all logic on posedge
//   rst  : asynchronous reset, active low
//   ctrl : slave side of dz_countdown_ctrl_if (commands in, digit/scan/status out)
module dz_countdown_ctrl #(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned SCAN_DIV  = 6_250,
    parameter int unsigned START_NUM = 5,
    parameter int unsigned DONE_HOLD = 3
) (
    input logic                clk,
    input logic                rst,
    dz_countdown_ctrl_if.slave ctrl
);

    localparam int unsigned TickW = $clog2(TICK_DIV);
    // Divisors of 1 would give zero-width counters; keep at least one bit.
    localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned HoldW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
    localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(DONE_HOLD - 1);
    localparam logic [2:0]       StartNum = 3'(START_NUM);

    typedef enum logic [1:0] {StIdle, StCount, StPause, StDone} state_e;

    state_e           state_q, state_d;
    logic [2:0]       num_q, num_d;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]       row_idx_q, row_idx_d;
    logic [7:0]       row_sel_q, row_sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic tick;
    logic scan_wrap;

    assign tick      = (tick_cnt_q == TickLast);
    assign scan_wrap = (scan_cnt_q == ScanLast);

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        tick_cnt_d = tick_cnt_q;
        hold_cnt_d = hold_cnt_q;

        unique case (state_q)
            StIdle: begin
                num_d      = StartNum;
                tick_cnt_d = '0;
                hold_cnt_d = '0;
                // start wins over a simultaneous pause simply because pause is unused here.
                if (ctrl.start) begin
                    state_d = StCount;
                end
            end
            StCount: begin
                // The cycle in which pause is sampled still counts, so a pause that
                // lands on a tick applies that tick's decrement.
                tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
                if (tick && num_q <= 3'd1) begin
                    num_d      = 3'd0;
                    hold_cnt_d = '0;
                    state_d    = StDone;
                end else begin
                    if (tick) begin
                        num_d = num_q - 3'd1;
                    end
                    if (ctrl.pause) begin
                        state_d = StPause;
                    end
                end
            end
            StPause: begin
                if (ctrl.start || ctrl.pause) begin
                    state_d = StCount;
                end
            end
            StDone: begin
                num_d      = 3'd0;
                tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
                if (tick) begin
                    if (hold_cnt_q == HoldLast) begin
                        hold_cnt_d = '0;
                        num_d      = StartNum;
                        state_d    = StIdle;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HoldW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (ctrl.clear) begin
            state_d    = StIdle;
            num_d      = StartNum;
            tick_cnt_d = '0;
            hold_cnt_d = '0;
        end

        busy_d = (state_d == StCount) || (state_d == StPause);
        done_d = (state_d == StDone);

        // Row scan runs in every state; only rst touches it.
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + ScanW'(1);
        row_idx_d  = scan_wrap ? row_idx_q + 3'd1 : row_idx_q;
        row_sel_d  = 8'b0000_0001 << row_idx_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            num_q      <= StartNum;
            tick_cnt_q <= '0;
            hold_cnt_q <= '0;
            scan_cnt_q <= '0;
            row_idx_q  <= 3'd0;
            row_sel_q  <= 8'b0000_0001;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            tick_cnt_q <= tick_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            row_idx_q  <= row_idx_d;
            row_sel_q  <= row_sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ctrl.num     = num_q;
    assign ctrl.row_idx = row_idx_q;
    assign ctrl.row_sel = row_sel_q;
    assign ctrl.busy    = busy_q;
    assign ctrl.done    = done_q;

endmodule
